// File: rtl/fifo_read_port.sv
// fifo_read_port: read side of an 8-entry register-bank FIFO.
// Tracks read pointer and fill count; reports read ack/error.
module fifo_read_port #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_en,
  input  logic             wr_done,
  input  logic [WIDTH-1:0] d_in0,
  input  logic [WIDTH-1:0] d_in1,
  input  logic [WIDTH-1:0] d_in2,
  input  logic [WIDTH-1:0] d_in3,
  input  logic [WIDTH-1:0] d_in4,
  input  logic [WIDTH-1:0] d_in5,
  input  logic [WIDTH-1:0] d_in6,
  input  logic [WIDTH-1:0] d_in7,
  output logic [WIDTH-1:0] d_out,
  output logic             rd_ack,
  output logic             rd_err,
  output logic             empty,
  output logic             full,
  output logic [2:0]       rd_ptr,
  output logic [3:0]       data_count
);

  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RD_ERR
  } state_t;

  state_t state;
  state_t state_next;

  logic             rd_ok;
  logic             rd_bad;
  logic [WIDTH-1:0] rd_word;
  logic [3:0]       count_next;

  assign empty  = (data_count == 4'd0);
  assign full   = (data_count == FULL_CNT);
  assign rd_ok  = rd_en && !empty;
  assign rd_bad = rd_en && empty;
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERR);

  // Select the bank register addressed by the read pointer.
  always_comb begin
    rd_word = d_in0;
    case (rd_ptr)
      3'd0: rd_word = d_in0;
      3'd1: rd_word = d_in1;
      3'd2: rd_word = d_in2;
      3'd3: rd_word = d_in3;
      3'd4: rd_word = d_in4;
      3'd5: rd_word = d_in5;
      3'd6: rd_word = d_in6;
      3'd7: rd_word = d_in7;
      default: rd_word = d_in0;
    endcase
  end

  // Next state records this cycle's read outcome.
  always_comb begin
    state_next = IDLE;
    unique case (1'b1)
      rd_ok:   state_next = READ;
      rd_bad:  state_next = RD_ERR;
      default: state_next = IDLE;
    endcase
  end

  // Fill count: a write while full is dropped, read+write cancels.
  always_comb begin
    count_next = data_count;
    if (wr_done && !rd_ok && !full)
      count_next = data_count + 4'd1;
    else if (rd_ok && !wr_done)
      count_next = data_count - 4'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Read data, pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out      <= '0;
      rd_ptr     <= 3'd0;
      data_count <= 4'd0;
    end else begin
      if (rd_ok) begin
        d_out  <= rd_word;
        rd_ptr <= rd_ptr + 3'd1;
      end
      data_count <= count_next;
    end
  end

endmodule

// File: tb/tb_fifo_read_port.sv
// tb_fifo_read_port: scoreboard bench with a queue-free count model.
// Directed corner cases followed by randomized traffic.
module tb_fifo_read_port;

  logic        clk;
  logic        reset_n;
  logic        rd_en;
  logic        wr_done;
  logic [31:0] bank [8];
  logic [31:0] d_out;
  logic        rd_ack;
  logic        rd_err;
  logic        empty;
  logic        full;
  logic [2:0]  rd_ptr;
  logic [3:0]  data_count;

  typedef struct {
    logic [31:0] dout;
    logic        ack;
    logic        err;
    logic [2:0]  ptr;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  int          m_cnt;
  int          m_ptr;
  logic [31:0] m_dout;

  fifo_read_port #(.DEPTH(8), .WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en),
    .wr_done    (wr_done),
    .d_in0      (bank[0]),
    .d_in1      (bank[1]),
    .d_in2      (bank[2]),
    .d_in3      (bank[3]),
    .d_in4      (bank[4]),
    .d_in5      (bank[5]),
    .d_in6      (bank[6]),
    .d_in7      (bank[7]),
    .d_out      (d_out),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .empty      (empty),
    .full       (full),
    .rd_ptr     (rd_ptr),
    .data_count (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model one clock edge with the given request inputs.
  task automatic step(input logic rd, input logic wr);
    exp_t e;
    int ok;
    ok = (rd && m_cnt > 0) ? 1 : 0;
    e.ack = (ok == 1);
    e.err = rd && (m_cnt == 0);
    if (ok == 1) begin
      m_dout = bank[m_ptr];
      m_ptr  = (m_ptr + 1) % 8;
    end
    m_cnt = m_cnt - ok + (wr ? 1 : 0);
    if (m_cnt > 8) m_cnt = 8;
    e.dout = m_dout;
    e.ptr  = 3'(m_ptr);
    e.cnt  = 4'(m_cnt);
    q.push_back(e);
  endtask

  task automatic cyc(input logic rd, input logic wr);
    @(negedge clk);
    rd_en   = rd;
    wr_done = wr;
    step(rd, wr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rd_en   = 1'b0;
    wr_done = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_dout",  d_out, 32'h0);
    chk("rst_ptr",   32'(rd_ptr), 32'h0);
    chk("rst_cnt",   32'(data_count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full",  32'(full), 32'h0);
    chk("rst_ack",   32'(rd_ack), 32'h0);
    chk("rst_err",   32'(rd_err), 32'h0);
    m_cnt  = 0;
    m_ptr  = 0;
    m_dout = 32'h0;
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs after each edge with queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("d_out", d_out, e.dout);
        chk("rd_ack", 32'(rd_ack), 32'(e.ack));
        chk("rd_err", 32'(rd_err), 32'(e.err));
        chk("rd_ptr", 32'(rd_ptr), 32'(e.ptr));
        chk("data_count", 32'(data_count), 32'(e.cnt));
        chk("empty", 32'(empty), 32'(e.cnt == 4'd0));
        chk("full", 32'(full), 32'(e.cnt == 4'd8));
      end
    end
  end

  initial begin
    int p_rd;
    int p_wr;
    int guard;
    reset_n = 1'b0;
    rd_en   = 1'b0;
    wr_done = 1'b0;
    for (int i = 0; i < 8; i++)
      bank[i] = 32'h1000_0000 + 32'(i);
    m_cnt  = 0;
    m_ptr  = 0;
    m_dout = 32'h0;
    do_reset();

    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    repeat (3) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    repeat (9) cyc(1'b0, 1'b1);
    repeat (8) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);

    repeat (4) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b0);

    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);

    repeat (8) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);

    do_reset();
    repeat (7) cyc(1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    do_reset();

    for (int blk = 0; blk < 20; blk++) begin
      p_rd = $urandom_range(10, 90);
      p_wr = $urandom_range(10, 90);
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0)
          bank[$urandom_range(0, 7)] = $urandom;
        rd_en   = ($urandom_range(0, 99) < p_rd);
        wr_done = ($urandom_range(0, 99) < p_wr);
        step(rd_en, wr_done);
      end
      if (blk == 10) do_reset();
    end

    cyc(1'b0, 1'b0);
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
